// File: rtl/freq_div_pkg.sv
// Shared constants and types for the multi-channel frequency divider.
// Contents:
//   mode_e       - channel output mode (toggle square wave / 1-cycle strobe)
//   DEF_W        - default divisor/counter width
//   DEF_DIV      - default divisor applied at reset
//   MAX_CH       - largest supported channel count
package freq_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_STROBE = 1'b1
    } mode_e;

    localparam int unsigned DEF_W   = 24;
    localparam int unsigned DEF_DIV = 11;
    localparam int unsigned MAX_CH  = 8;

endpackage

// File: rtl/freq_div_chan.sv
// One divider channel: period counter, shadow (pending) divisor/mode with
// BUSY handshake, and registered TICK / CLK_OUT outputs.
// Ports:
//   clk_i      system clock, posedge
//   rst_i      synchronous active-high reset
//   en_i       run enable (level)
//   load_i     1-cycle request to capture div_i/mode_i into the shadow
//   div_i      requested divisor (period = div+1 cycles per tick)
//   mode_i     requested mode (0 toggle, 1 strobe)
//   clk_out_o  toggle: square wave of period 2*(div+1); strobe: equals tick_o
//   tick_o     1-cycle pulse at each terminal count
//   busy_o     high while a loaded value waits to become active
module freq_div_chan
    import freq_div_pkg::*;
#(
    parameter int unsigned W            = DEF_W,
    parameter int unsigned DEFAULT_DIV  = DEF_DIV,
    parameter mode_e       DEFAULT_MODE = MODE_TOGGLE
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] div_i,
    input  logic         mode_i,
    output logic         clk_out_o,
    output logic         tick_o,
    output logic         busy_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] sh_div_q, sh_div_d;
    mode_e        mode_q, mode_d;
    mode_e        sh_mode_q, sh_mode_d;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;
    logic         busy_q, busy_d;

    logic         terminal;
    logic         apply;

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        sh_div_d  = sh_div_q;
        mode_d    = mode_q;
        sh_mode_d = sh_mode_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        busy_d    = busy_q;

        terminal  = en_i && (cnt_q == div_q);
        // A pending value goes live at a wrap, or immediately while idle.
        // busy_q is only set by an earlier LOAD, so a LOAD on this very edge
        // never takes effect on this edge's wrap.
        apply     = busy_q && (terminal || !en_i);

        if (en_i) begin
            tick_d = terminal;
            cnt_d  = terminal ? '0 : cnt_q + 1'b1;
            if (mode_q == MODE_STROBE) begin
                clk_out_d = terminal;
            end else if (terminal) begin
                clk_out_d = ~clk_out_q;
            end
        end else begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end

        if (apply) begin
            div_d  = sh_div_q;
            mode_d = sh_mode_q;
            cnt_d  = '0;
            busy_d = 1'b0;
            if (sh_mode_q != mode_q) begin
                clk_out_d = 1'b0;
            end
        end

        // Capture after apply so a LOAD on an apply edge stays pending.
        if (load_i) begin
            sh_div_d  = div_i;
            sh_mode_d = mode_e'(mode_i);
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            div_q     <= W'(DEFAULT_DIV);
            sh_div_q  <= '0;
            mode_q    <= DEFAULT_MODE;
            sh_mode_q <= MODE_TOGGLE;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            sh_div_q  <= sh_div_d;
            mode_q    <= mode_d;
            sh_mode_q <= sh_mode_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/freq_div_multi.sv
// N-channel clock-enable / frequency generator. Each channel has its own
// runtime divisor, toggle/strobe mode, enable and glitch-free reload.
// Ports:
//   CLK      system clock, posedge
//   RST      synchronous active-high reset
//   EN       per-channel run enable
//   LOAD     per-channel 1-cycle reload request
//   DIV_IN   per-channel divisor, slice i = [i*W +: W]
//   MODE_IN  per-channel mode captured with LOAD (0 toggle, 1 strobe)
//   CLK_OUT  per-channel square wave (toggle) or strobe
//   TICK     per-channel terminal-count pulse
//   BUSY     per-channel reload-pending flag
module freq_div_multi
    import freq_div_pkg::*;
#(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned W            = DEF_W,
    parameter int unsigned DEFAULT_DIV  = DEF_DIV,
    parameter bit          DEFAULT_MODE = 1'b0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_CH-1:0]     EN,
    input  logic [N_CH-1:0]     LOAD,
    input  logic [N_CH*W-1:0]   DIV_IN,
    input  logic [N_CH-1:0]     MODE_IN,
    output logic [N_CH-1:0]     CLK_OUT,
    output logic [N_CH-1:0]     TICK,
    output logic [N_CH-1:0]     BUSY
);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        freq_div_chan #(
            .W            (W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_MODE (mode_e'(DEFAULT_MODE))
        ) u_chan (
            .clk_i     (CLK),
            .rst_i     (RST),
            .en_i      (EN[g]),
            .load_i    (LOAD[g]),
            .div_i     (DIV_IN[g*W +: W]),
            .mode_i    (MODE_IN[g]),
            .clk_out_o (CLK_OUT[g]),
            .tick_o    (TICK[g]),
            .busy_o    (BUSY[g])
        );
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// Scoreboard bench: dut_a is the default 2-channel W=24 build, dut_b a
// 1-channel W=8 build used for the maximum-divisor wrap. Model channels
// 0,1 belong to dut_a, channel 2 to dut_b.
module tb_freq_div_multi;

    logic        CLK;
    logic        rst;
    logic [1:0]  en_a, load_a, mode_a;
    logic [47:0] div_a;
    logic        en_b, load_b, mode_b;
    logic [7:0]  div_b;
    logic [1:0]  clk_out_a, tick_a, busy_a;
    logic        clk_out_b, tick_b, busy_b;

    freq_div_multi #(.N_CH(2), .W(24), .DEFAULT_DIV(11), .DEFAULT_MODE(1'b0)) dut_a (
        .CLK(CLK), .RST(rst), .EN(en_a), .LOAD(load_a), .DIV_IN(div_a), .MODE_IN(mode_a),
        .CLK_OUT(clk_out_a), .TICK(tick_a), .BUSY(busy_a)
    );

    freq_div_multi #(.N_CH(1), .W(8), .DEFAULT_DIV(11), .DEFAULT_MODE(1'b0)) dut_b (
        .CLK(CLK), .RST(rst), .EN(en_b), .LOAD(load_b), .DIV_IN(div_b), .MODE_IN(mode_b),
        .CLK_OUT(clk_out_b), .TICK(tick_b), .BUSY(busy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] tick;
        logic [2:0] clk;
        logic [2:0] busy;
    } exp_t;

    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    // Reference model: period length, edges elapsed in the current period,
    // number of completed periods since the last restart (its parity is the
    // toggle output), and a pending reload slot.
    longint unsigned m_div[3], m_el[3], m_shd[3], m_nper[3];
    bit              m_mode[3], m_shm[3], m_busy[3], m_tick[3], m_clk[3];

    task automatic model_chan(input int c, input bit r, input bit en, input bit ld,
                              input longint unsigned dv, input bit md);
        bit wrap, old_mode, force0;
        if (r) begin
            m_div[c] = 11; m_mode[c] = 1'b0; m_el[c] = 0; m_nper[c] = 0;
            m_busy[c] = 1'b0; m_tick[c] = 1'b0; m_clk[c] = 1'b0;
            return;
        end
        wrap     = en && (m_el[c] + 1 == m_div[c] + 1);
        old_mode = m_mode[c];
        force0   = 1'b0;
        if (en) begin
            if (wrap) begin m_el[c] = 0; m_nper[c]++; end
            else m_el[c]++;
        end else begin
            m_el[c] = 0; m_nper[c] = 0;
        end
        if (m_busy[c] && (wrap || !en)) begin
            if (m_shm[c] != m_mode[c]) begin m_nper[c] = 0; force0 = 1'b1; end
            m_div[c] = m_shd[c]; m_mode[c] = m_shm[c]; m_el[c] = 0; m_busy[c] = 1'b0;
        end
        m_tick[c] = wrap;
        m_clk[c]  = (!en || force0) ? 1'b0 : (old_mode ? wrap : m_nper[c][0]);
        if (ld) begin m_shd[c] = dv; m_shm[c] = md; m_busy[c] = 1'b1; end
    endtask

    task automatic drive_cycle();
        exp_t e;
        model_chan(0, rst, en_a[0], load_a[0], longint'(div_a[23:0]), mode_a[0]);
        model_chan(1, rst, en_a[1], load_a[1], longint'(div_a[47:24]), mode_a[1]);
        model_chan(2, rst, en_b, load_b, longint'(div_b), mode_b);
        for (int i = 0; i < 3; i++) begin
            e.tick[i] = m_tick[i]; e.clk[i] = m_clk[i]; e.busy[i] = m_busy[i];
        end
        sb.push_back(e);
        @(negedge CLK);
        cyc++;
        load_a = '0;
        load_b = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
    endtask

    // Monitor: every registered output update is compared against the
    // oldest expectation pushed by the stimulus side.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("TICK",    {tick_b, tick_a},       e.tick);
                check("CLK_OUT", {clk_out_b, clk_out_a}, e.clk);
                check("BUSY",    {busy_b, busy_a},       e.busy);
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; en_a = '0; load_a = '0; mode_a = '0; div_a = '0;
        en_b = 1'b0; load_b = 1'b0; mode_b = 1'b0; div_b = '0;
        for (int c = 0; c < 3; c++) begin m_shd[c] = 0; m_shm[c] = 0; end
        run(1);
        rst = 1'b1;
        run(2);

        // Defaults on ch0; dut_b gets the maximum divisor.
        en_a = 2'b01;
        en_b = 1'b1; load_b = 1'b1; div_b = 8'hFF; mode_b = 1'b0;
        run(60);

        // ch1 to DIV=3 strobe.
        en_a = 2'b11;
        load_a = 2'b10; div_a[47:24] = 24'd3; mode_a[1] = 1'b1;
        run(30);

        // ch0 reload mid-period, then overwrite while pending.
        guard = 0;
        while (m_el[0] != 5 && guard < 100) begin drive_cycle(); guard++; end
        load_a = 2'b01; div_a[23:0] = 24'd4; mode_a[0] = 1'b0;
        run(3);
        load_a = 2'b01; div_a[23:0] = 24'd7;
        run(40);

        // Zero divisor: ch0 toggle, ch1 strobe.
        load_a = 2'b11; div_a = '0; mode_a = 2'b10;
        run(25);

        // Enable drop mid-period on ch0.
        load_a = 2'b01; div_a[23:0] = 24'd9; mode_a[0] = 1'b0;
        run(15);
        guard = 0;
        while (m_el[0] != 6 && guard < 100) begin drive_cycle(); guard++; end
        en_a[0] = 1'b0;
        run(3);
        en_a[0] = 1'b1;
        run(25);

        // Let the 256-cycle period on dut_b repeat a few times.
        while (cyc < 800) drive_cycle();

        // Reset with a reload pending: pending value must be discarded.
        load_a = 2'b01; div_a[23:0] = 24'd2; mode_a[0] = 1'b1;
        run(2);
        rst = 1'b1;
        run(1);
        run(40);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            en_a = {($urandom_range(0, 15) != 0), ($urandom_range(0, 15) != 0)};
            en_b = ($urandom_range(0, 15) != 0);
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 19) == 0) begin
                    load_a[c] = 1'b1;
                    div_a[c*24 +: 24] = 24'($urandom_range(0, 15));
                    mode_a[c] = 1'($urandom_range(0, 1));
                end
            end
            if ($urandom_range(0, 19) == 0) begin
                load_b = 1'b1;
                div_b  = 8'($urandom_range(0, 255));
                mode_b = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            drive_cycle();
        end

        en_a = '0; en_b = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
